// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - default widths and FSM state encoding for the cache refill controller
package cache_pkg;

  localparam int CACHE_DATA_WIDTH         = 32;
  localparam int CACHE_ADDR_WIDTH         = 10;
  localparam int CACHE_INDEX_WIDTH        = 5;
  localparam int CACHE_TAG_WIDTH          = 2;
  localparam int CACHE_BLOCK_OFFSET_WIDTH = 3;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITEBACK = 2'd1;
  localparam logic [1:0] ST_REFILL    = 2'd2;
  localparam logic [1:0] ST_COMMIT    = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    WRITEBACK = ST_WRITEBACK,
    REFILL    = ST_REFILL,
    COMMIT    = ST_COMMIT
  } refill_state_e;

endpackage

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - write-back cache miss controller (writeback, refill, commit); CACHE_PERF_CNT_EN adds hit/miss counters
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH         = CACHE_DATA_WIDTH,
  parameter int ADDR_WIDTH         = CACHE_ADDR_WIDTH,
  parameter int INDEX_WIDTH        = CACHE_INDEX_WIDTH,
  parameter int TAG_WIDTH          = CACHE_TAG_WIDTH,
  parameter int BLOCK_OFFSET_WIDTH = CACHE_BLOCK_OFFSET_WIDTH
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          cpu_req,
  input  logic                          cpu_we,
  input  logic [ADDR_WIDTH-1:0]         cpu_addr,
  output logic                          cpu_ready,
  input  logic                          hit,
  input  logic                          line_dirty,
  input  logic [TAG_WIDTH-1:0]          line_tag,
  output logic                          arr_word_we,
  output logic                          arr_fill_we,
  output logic [BLOCK_OFFSET_WIDTH-1:0] arr_offset,
  output logic                          arr_line_done,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
`ifdef CACHE_PERF_CNT_EN
  output logic [31:0]                   hit_cnt,
  output logic [31:0]                   miss_cnt,
`endif
  input  logic                          mem_ack
);

  if (TAG_WIDTH + INDEX_WIDTH + BLOCK_OFFSET_WIDTH != ADDR_WIDTH || DATA_WIDTH < 1) begin : g_bad_cfg
    $error("cache_refill_ctrl: address field widths do not add up to ADDR_WIDTH");
  end

  refill_state_e                 state_q;
  logic [BLOCK_OFFSET_WIDTH-1:0] cnt_q;
  logic [TAG_WIDTH-1:0]          wb_tag_q;
  logic [TAG_WIDTH-1:0]          req_tag_q;
  logic [INDEX_WIDTH-1:0]        index_q;
  logic                          in_idle;
  logic                          miss_entry;
  logic                          last_beat;
  logic                          unused_offset;

  // Word offset is consumed by the array directly; the controller only walks whole lines.
  assign unused_offset = ^cpu_addr[BLOCK_OFFSET_WIDTH-1:0];

  assign in_idle    = (state_q == IDLE);
  assign miss_entry = in_idle && cpu_req && !hit;
  assign last_beat  = (cnt_q == {BLOCK_OFFSET_WIDTH{1'b1}});

  // Line address and victim tag are latched at miss entry so the sequence survives cpu_req dropping.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wb_tag_q  <= '0;
      req_tag_q <= '0;
      index_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_entry) begin
            cnt_q     <= '0;
            wb_tag_q  <= line_tag;
            req_tag_q <= cpu_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
            index_q   <= cpu_addr[BLOCK_OFFSET_WIDTH +: INDEX_WIDTH];
            state_q   <= line_dirty ? WRITEBACK : REFILL;
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_beat) state_q <= REFILL;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_beat) state_q <= COMMIT;
          end
        end
        COMMIT:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_ready     = rstn && in_idle && cpu_req && hit;
    arr_word_we   = cpu_ready && cpu_we;
    mem_req       = (state_q == WRITEBACK) || (state_q == REFILL);
    mem_we        = (state_q == WRITEBACK);
    arr_fill_we   = rstn && (state_q == REFILL) && mem_ack;
    arr_line_done = rstn && (state_q == COMMIT);
    arr_offset    = '0;
    mem_addr      = '0;
    if (state_q == WRITEBACK) begin
      arr_offset = cnt_q;
      mem_addr   = {wb_tag_q, index_q, cnt_q};
    end else if (state_q == REFILL) begin
      arr_offset = cnt_q;
      mem_addr   = {req_tag_q, index_q, cnt_q};
    end
  end

`ifdef CACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (cpu_ready && (hit_cnt != 32'hFFFF_FFFF))
        hit_cnt <= hit_cnt + 32'd1;
      if (miss_entry && (miss_cnt != 32'hFFFF_FFFF))
        miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - directed self-checking bench for cache_refill_ctrl
module tb_cache_refill_ctrl;

  logic       clk;
  logic       rstn;
  logic       cpu_req;
  logic       cpu_we;
  logic [9:0] cpu_addr;
  logic       cpu_ready;
  logic       hit;
  logic       line_dirty;
  logic [1:0] line_tag;
  logic       arr_word_we;
  logic       arr_fill_we;
  logic [2:0] arr_offset;
  logic       arr_line_done;
  logic       mem_req;
  logic       mem_we;
  logic [9:0] mem_addr;
  logic       mem_ack;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int n_checks;
  int n_fail;

  cache_refill_ctrl dut (
    .clk           (clk),
    .rstn          (rstn),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_ready     (cpu_ready),
    .hit           (hit),
    .line_dirty    (line_dirty),
    .line_tag      (line_tag),
    .arr_word_we   (arr_word_we),
    .arr_fill_we   (arr_fill_we),
    .arr_offset    (arr_offset),
    .arr_line_done (arr_line_done),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
`ifdef CACHE_PERF_CNT_EN
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt),
`endif
    .mem_ack       (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one miss to completion; memory acks each beat after `gap` idle cycles (gap 0 = ack held high).
  task automatic run_miss(input logic [9:0] addr, input logic [1:0] ltag, input logic dirty,
                          input logic we, input int gap,
                          input logic [9:0] wb_base, input logic [9:0] rd_base,
                          output int ready_cyc, output int n_wb, output int n_fill,
                          output int n_done, output int n_bad);
    int         wait_c;
    logic       done_seen;
    logic       fin;
    logic [9:0] exp_addr;
    logic [2:0] exp_off;
    ready_cyc = 0; n_wb = 0; n_fill = 0; n_done = 0; n_bad = 0;
    wait_c = 0; done_seen = 1'b0; fin = 1'b0;
    for (int cyc = 1; cyc <= 300 && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr;
        hit = 1'b0; line_dirty = dirty; line_tag = ltag;
      end
      if (done_seen) hit = 1'b1;
      if (gap == 0) mem_ack = 1'b1;
      else          mem_ack = mem_req && (wait_c == gap);
      #1;
      if (mem_req) begin
        exp_addr = mem_we ? (wb_base + 10'(n_wb)) : (rd_base + 10'(n_fill));
        exp_off  = mem_we ? 3'(n_wb) : 3'(n_fill);
        if (mem_addr !== exp_addr || arr_offset !== exp_off) n_bad++;
        if (cpu_ready || arr_word_we || arr_line_done) n_bad++;
        if (mem_ack) begin
          wait_c = 0;
          if (mem_we) n_wb++;
        end else begin
          wait_c++;
        end
      end
      if (arr_fill_we) n_fill++;
      if (arr_line_done) begin
        n_done++;
        done_seen = 1'b1;
        if (mem_req || cpu_ready) n_bad++;
      end
      if (cpu_ready) begin
        ready_cyc = cyc;
        fin = 1'b1;
        if (arr_word_we !== we) n_bad++;
      end
    end
    @(negedge clk);
    cpu_req = 1'b0; hit = 1'b0; mem_ack = 1'b0; cpu_we = 1'b0;
  endtask

  int rc, nwb, nfill, ndone, nbad;

  initial begin
    n_checks = 0; n_fail = 0;
    rstn = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
    hit = 1'b0; line_dirty = 1'b0; line_tag = '0; mem_ack = 1'b0;

    // Reset cycle: combinational hit terms must stay low even with a hitting request.
    repeat (2) @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; hit = 1'b1; mem_ack = 1'b1;
    #1;
    check_eq("rst_cpu_ready", cpu_ready, 0);
    check_eq("rst_arr_word_we", arr_word_we, 0);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_line_done", arr_line_done, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    @(negedge clk);
    rstn = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; hit = 1'b0; mem_ack = 1'b0;

    // Clean miss, ack every cycle.
    run_miss(10'h008, 2'd0, 1'b0, 1'b0, 0, 10'h000, 10'h008, rc, nwb, nfill, ndone, nbad);
    check_eq("clean_ready_cycle", rc, 11);
    check_eq("clean_wb_beats", nwb, 0);
    check_eq("clean_fills", nfill, 8);
    check_eq("clean_line_done", ndone, 1);
    check_eq("clean_seq_errors", nbad, 0);

    // Dirty miss: writeback of tag 1 then refill of tag 2.
    run_miss(10'h208, 2'd1, 1'b1, 1'b0, 0, 10'h108, 10'h208, rc, nwb, nfill, ndone, nbad);
    check_eq("dirty_ready_cycle", rc, 19);
    check_eq("dirty_wb_beats", nwb, 8);
    check_eq("dirty_fills", nfill, 8);
    check_eq("dirty_line_done", ndone, 1);
    check_eq("dirty_seq_errors", nbad, 0);

    // Slow memory: 3 idle cycles before each ack, write request.
    run_miss(10'h0C8, 2'd3, 1'b0, 1'b1, 3, 10'h000, 10'h0C8, rc, nwb, nfill, ndone, nbad);
    check_eq("gap_ready_cycle", rc, 35);
    check_eq("gap_fills", nfill, 8);
    check_eq("gap_line_done", ndone, 1);
    check_eq("gap_seq_errors", nbad, 0);

    // Hits complete in the same cycle without touching memory.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h155; hit = 1'b1;
    #1;
    check_eq("hitw_cpu_ready", cpu_ready, 1);
    check_eq("hitw_arr_word_we", arr_word_we, 1);
    check_eq("hitw_mem_req", mem_req, 0);
    @(negedge clk);
    cpu_we = 1'b0;
    #1;
    check_eq("hitr_cpu_ready", cpu_ready, 1);
    check_eq("hitr_arr_word_we", arr_word_we, 0);
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    check_eq("noreq_cpu_ready", cpu_ready, 0);
    check_eq("noreq_mem_req", mem_req, 0);

    // Reset during refill beat 4.
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 10'h2A0; hit = 1'b0; line_dirty = 1'b0; mem_ack = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check_eq("rstmid_beat4_addr", mem_addr, 10'h2A4);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1; cpu_req = 1'b0;
    #1;
    check_eq("rstmid_mem_req", mem_req, 0);
    check_eq("rstmid_fill_we", arr_fill_we, 0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (arr_line_done || mem_req) ndone++;
    end
    check_eq("rstmid_no_commit", ndone, 0);
    mem_ack = 1'b0;

`ifdef CACHE_PERF_CNT_EN
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check_eq("perf_hit_rst", hit_cnt, 0);
    check_eq("perf_miss_rst", miss_cnt, 0);
    cpu_req = 1'b1; cpu_addr = 10'h011; hit = 1'b1;
    repeat (3) @(negedge clk);
    cpu_req = 1'b0; hit = 1'b0;
    run_miss(10'h010, 2'd0, 1'b0, 1'b0, 0, 10'h000, 10'h010, rc, nwb, nfill, ndone, nbad);
    #1;
    check_eq("perf_hit_cnt", hit_cnt, 4);
    check_eq("perf_miss_cnt", miss_cnt, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, word address width.
REQ-003 SHALL have parameter INDEX_WIDTH, default 5, line index width.
REQ-004 SHALL have parameter TAG_WIDTH, default 2, tag width.
REQ-005 SHALL have parameter BLOCK_OFFSET_WIDTH, default 3, word-in-line offset width; BLOCK_SIZE = 2**BLOCK_OFFSET_WIDTH.
REQ-006 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-007 SHALL have port rstn, input, 1, reset, synchronous, active-low.
REQ-008 SHALL have port cpu_req, input, 1, access request; cpu_addr and cpu_we held stable until cpu_ready.
REQ-009 SHALL have port cpu_we, input, 1, request is a write.
REQ-010 SHALL have port cpu_addr, input, ADDR_WIDTH, {tag, index, offset}.
REQ-011 SHALL have port cpu_ready, output, 1, access completes this cycle.
REQ-012 SHALL have port hit, input, 1, array lookup result for cpu_addr (valid & tag match).
REQ-013 SHALL have port line_dirty, input, 1, indexed line valid and dirty.
REQ-014 SHALL have port line_tag, input, TAG_WIDTH, tag stored in indexed line.
REQ-015 SHALL have port arr_word_we, output, 1, write cpu data word at cpu_addr offset.
REQ-016 SHALL have port arr_fill_we, output, 1, write mem_rdata into line at arr_offset.
REQ-017 SHALL have port arr_offset, output, BLOCK_OFFSET_WIDTH, array word select for writeback read and refill write.
REQ-018 SHALL have port arr_line_done, output, 1, one-cycle pulse: set valid, load tag, clear dirty.
REQ-019 SHALL have port mem_req, output, 1, memory beat request.
REQ-020 SHALL have port mem_we, output, 1, beat is writeback.
REQ-021 SHALL have port mem_addr, output, ADDR_WIDTH, beat word address.
REQ-022 SHALL have port mem_ack, input, 1, current beat complete (read data valid / write accepted).

Function
REQ-023 SHALL implement FSM states IDLE, WRITEBACK, REFILL, COMMIT, with a BLOCK_OFFSET_WIDTH beat counter.
REQ-024 IDLE, cpu_req & hit: cpu_ready=1 and arr_word_we=cpu_we combinationally, same cycle; stay IDLE.
REQ-025 IDLE, cpu_req & !hit & line_dirty: counter<=0, go WRITEBACK; !line_dirty: counter<=0, go REFILL.
REQ-026 WRITEBACK: mem_req=1, mem_we=1, mem_addr={line_tag, index, counter}, arr_offset=counter; tag captured at miss entry.
REQ-027 REFILL: mem_req=1, mem_we=0, mem_addr={cpu tag, index, counter}; on mem_ack arr_fill_we=1, arr_offset=counter.
REQ-028 Counter SHALL advance only on mem_ack; mem_addr stable between acks; ack on beat BLOCK_SIZE-1 wraps counter to 0 and exits (WRITEBACK->REFILL, REFILL->COMMIT).
REQ-029 COMMIT: arr_line_done=1 for exactly one cycle, then IDLE, where the retried lookup hits and completes.
REQ-030 cpu_ready, arr_word_we SHALL be 0 outside IDLE; mem_req 0 in IDLE and COMMIT; mem_ack there ignored.
REQ-031 cpu_req deasserted mid-miss: sequence SHALL run to COMMIT; no abort.
REQ-032 Clean-miss latency: 1 + BLOCK_SIZE beats + 1 cycle before cpu_ready; dirty miss adds BLOCK_SIZE beats.

Reset
REQ-033 rstn=0 at rising edge SHALL force IDLE, counter 0; all outputs 0 except combinational IDLE terms (cpu_ready, arr_word_we) during reset cycle held 0.
REQ-034 Reset mid-miss SHALL drop mem_req next edge and never pulse arr_line_done for the interrupted line.

Configuration
REQ-035 With CACHE_PERF_CNT_EN defined: outputs hit_cnt, miss_cnt (32 bits each) count completed IDLE hits and miss entries, saturating, reset to 0; without it, ports absent and no counter logic.

Structure
REQ-036 Package cache_pkg SHALL hold FSM state enum and default widths; no sub-module, controller is a single flat module.

Verification
REQ-037 Cold reset, cpu_req read addr 0x008, hit=0, dirty=0, ack every cycle -> 8 REFILL beats addr 0x008..0x00F, arr_line_done pulse, cpu_ready cycle 11.
REQ-038 Dirty miss, line_tag=1, cpu_addr=0x208 -> 8 writebacks 0x108..0x10F (mem_we=1), then reads 0x208..0x20F, then COMMIT.
REQ-039 Hit write, hit=1, cpu_we=1 -> cpu_ready and arr_word_we same cycle, mem_req stays 0.
REQ-040 mem_ack gaps of 3 cycles per beat -> mem_addr constant across gaps, exactly 8 arr_fill_we pulses.
REQ-041 rstn=0 during REFILL beat 4 -> next cycle IDLE, mem_req=0, no arr_line_done.
REQ-042 CACHE_PERF_CNT_EN build: 3 hits + 1 miss -> hit_cnt=4 (retry hit), miss_cnt=1.
